mem_access: RTL and testbench

Memory-access stage between execute and write-back in the multi-cycle CPU. Takes an executed instruction (op, ALU result, store data, branch flag), runs the data-memory transaction for loads and stores through a req/ack handshake with timeout, and presents a registered result (`op_o`, `write_o`, `ife_o`) plus a one-cycle `done` pulse to the write-back stage. Non-memory ops pass through in one cycle.

---
 rtl/mem_access.sv | 146 ++++++++++++++
 tb/tb_mem_access.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/mem_access.sv
// mem_access: memory-access stage between execute and write-back.
// When start is accepted in IDLE, the stage latches the executed instruction.
// Loads and stores then run one data-memory transaction over a req/ack
// handshake that has a timeout. Every other op passes straight through.
// Each result is registered and announced by a one-cycle done pulse.
//
// Ports
//   clk, rst             clock, synchronous active-high reset
//   start, op, alu_i,    executed instruction from execute
//   store_data, ife
//   mem_req, mem_we,     data-memory request side (held stable while mem_req)
//   mem_addr, mem_wdata
//   mem_ack, mem_rdata   data-memory completion
//   op_o, write_o, ife_o registered result for write-back
//   done                 one-cycle pulse, result valid
//   busy                 state != IDLE
//   err                  sticky timeout flag, cleared only by rst
module mem_access #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [5:0]  op,
  input  logic [31:0] alu_i,
  input  logic [31:0] store_data,
  input  logic        ife,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [5:0]  op_o,
  output logic [31:0] write_o,
  output logic        ife_o,
  output logic        done,
  output logic        busy,
  output logic        err
);
  localparam logic [5:0] OP_LD  = 6'b010001;
  localparam logic [5:0] OP_ST  = 6'b010000;
  localparam logic [5:0] OP_NOP = 6'b111111;
  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t        state_q, state_d;
  logic [5:0]    lop_q, lop_d;       // latched opcode
  logic [31:0]   addr_q, addr_d;     // latched alu_i
  logic [31:0]   wdata_q, wdata_d;   // latched store_data
  logic          life_q, life_d;     // latched ife
  logic [CW-1:0] cnt_q, cnt_d;       // REQ cycles already completed
  logic [5:0]    op_q, op_d;
  logic [31:0]   wr_q, wr_d;
  logic          ifo_q, ifo_d;
  logic          err_q, err_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      lop_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      life_q  <= 1'b0;
      cnt_q   <= '0;
      op_q    <= '0;
      wr_q    <= '0;
      ifo_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      lop_q   <= lop_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      life_q  <= life_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      wr_q    <= wr_d;
      ifo_q   <= ifo_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    lop_d   = lop_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    life_d  = life_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    wr_d    = wr_q;
    ifo_d   = ifo_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          lop_d   = op;
          addr_d  = alu_i;
          wdata_d = store_data;
          life_d  = ife;
          if (op == OP_LD || op == OP_ST) begin
            cnt_d   = '0;
            state_d = REQ;
          end else begin
            op_d    = op;
            wr_d    = alu_i;
            ifo_d   = ife;
            state_d = DONE;
          end
        end
      end
      REQ: begin
        cnt_d = cnt_q + CW'(1);
        // An ack in the final allowed cycle still counts as a completion.
        if (mem_ack) begin
          op_d    = lop_q;
          wr_d    = (lop_q == OP_LD) ? mem_rdata : addr_q;
          ifo_d   = life_q;
          state_d = DONE;
        end else if (cnt_q == CNT_LAST) begin
          err_d   = 1'b1;
          op_d    = OP_NOP;
          wr_d    = '0;
          ifo_d   = 1'b0;
          state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign mem_req   = (state_q == REQ);
  assign mem_we    = (state_q == REQ) && (lop_q == OP_ST);
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign op_o      = op_q;
  assign write_o   = wr_q;
  assign ife_o     = ifo_q;
  assign done      = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign err       = err_q;
endmodule

// File: tb/tb_mem_access.sv
module tb_mem_access;
  localparam int TIMEOUT = 16;
  localparam logic [5:0] OP_LD = 6'b010001;
  localparam logic [5:0] OP_ST = 6'b010000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [5:0]  op = '0;
  logic [31:0] alu_i = '0, store_data = '0;
  logic        ife = 1'b0;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic [5:0]  op_o;
  logic [31:0] write_o;
  logic        ife_o, done, busy, err;

  mem_access #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .alu_i(alu_i),
    .store_data(store_data), .ife(ife), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .op_o(op_o), .write_o(write_o), .ife_o(ife_o),
    .done(done), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  op;
    logic [31:0] wr;
    logic        ife;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  int          nchk = 0, nfail = 0;
  int          req_cnt = 0, done_cnt = 0;
  logic        exp_err = 1'b0;
  logic        cur_we = 1'b0;
  logic [31:0] cur_addr = '0, cur_wdata = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (!rst && mem_req) begin
      req_cnt++;
      chk("mem_we", 32'(mem_we), 32'(cur_we));
      chk("mem_addr", mem_addr, cur_addr);
      if (cur_we) chk("mem_wdata", mem_wdata, cur_wdata);
    end
    if (done) begin
      done_cnt++;
      if (sb.size() == 0) chk("unexpected_done", 32'(done), 32'd0);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("op_o", 32'(op_o), 32'(e.op));
        chk("write_o", write_o, e.wr);
        chk("ife_o", 32'(ife_o), 32'(e.ife));
        chk("err", 32'(err), 32'(e.err));
      end
    end
  end

  task automatic wait_idle();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!busy) break;
    end
    chk("idle_timeout", 32'(busy), 32'd0);
  endtask

  task automatic check_reset_vals();
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_op_o", 32'(op_o), 32'd0);
    chk("rst_write_o", write_o, 32'd0);
    chk("rst_ife_o", 32'(ife_o), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    sb.delete();
    exp_err = 1'b0;
    @(negedge clk);
    check_reset_vals();
  endtask

  // One transaction, started from IDLE. k = cycle of REQ in which ack is
  // given (1..TIMEOUT), 0 = never acked.
  task automatic run(input logic [5:0] o, input logic [31:0] a, input logic [31:0] sd,
                     input logic f, input int k, input logic [31:0] rd);
    exp_t e;
    bit   is_mem;
    int   exp_req, d0;
    is_mem = (o == OP_LD) || (o == OP_ST);
    if (!is_mem) begin
      e = '{op: o, wr: a, ife: f, err: exp_err};
      exp_req = 0;
    end else if (k >= 1 && k <= TIMEOUT) begin
      e = '{op: o, wr: (o == OP_LD) ? rd : a, ife: f, err: exp_err};
      exp_req = k;
    end else begin
      exp_err = 1'b1;
      e = '{op: 6'b111111, wr: 32'd0, ife: 1'b0, err: 1'b1};
      exp_req = TIMEOUT;
    end
    sb.push_back(e);
    cur_we = (o == OP_ST); cur_addr = a; cur_wdata = sd;
    req_cnt = 0; d0 = done_cnt;
    op = o; alu_i = a; store_data = sd; ife = f; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    if (is_mem && k >= 1) begin
      repeat (k - 1) begin @(posedge clk); #1; end
      mem_ack = 1'b1; mem_rdata = rd;
      @(posedge clk); #1 mem_ack = 1'b0; mem_rdata = '0;
    end
    wait_idle();
    chk("req_cycles", 32'(req_cnt), 32'(exp_req));
    chk("done_count", 32'(done_cnt - d0), 32'd1);
    chk("sb_drained", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    int d0;
    do_reset();

    // ALU pass-through
    run(6'b000001, 32'h0000_1234, 32'h0, 1'b0, 0, 32'h0);
    // Load, ack in third REQ cycle
    run(OP_LD, 32'h40, 32'h0, 1'b0, 3, 32'hDEAD_BEEF);
    // Store, ack in first REQ cycle
    run(OP_ST, 32'h80, 32'h55AA, 1'b0, 1, 32'h0);

    // Branch, second start held during DONE must be ignored
    sb.push_back('{op: 6'b100000, wr: 32'h100, ife: 1'b1, err: 1'b0});
    d0 = done_cnt;
    op = 6'b100000; alu_i = 32'h100; ife = 1'b1; start = 1'b1;
    @(posedge clk); #1 op = 6'b000011; alu_i = 32'hBAD; ife = 1'b0;
    @(posedge clk); #1 start = 1'b0;
    wait_idle();
    repeat (2) @(negedge clk);
    chk("busy_start_ignored", 32'(done_cnt - d0), 32'd1);
    chk("result_held", write_o, 32'h100);

    // Load timeout, then err stays set through a normal op
    run(OP_LD, 32'h200, 32'h0, 1'b0, 0, 32'h0);
    chk("err_sticky", 32'(err), 32'd1);
    run(6'b000010, 32'h77, 32'h0, 1'b0, 0, 32'h0);
    chk("err_sticky2", 32'(err), 32'd1);

    // Reset in the second REQ cycle
    sb.push_back('{op: OP_LD, wr: 32'h0, ife: 1'b0, err: 1'b1});
    cur_we = 1'b0; cur_addr = 32'h300;
    d0 = done_cnt;
    op = OP_LD; alu_i = 32'h300; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    sb.delete(); exp_err = 1'b0;
    @(negedge clk);
    check_reset_vals();
    mem_ack = 1'b1; mem_rdata = 32'h1111_2222;
    repeat (3) @(posedge clk);
    #1 mem_ack = 1'b0;
    @(negedge clk);
    chk("late_ack_no_done", 32'(done_cnt - d0), 32'd0);
    chk("late_ack_busy", 32'(busy), 32'd0);
    chk("late_ack_write", write_o, 32'd0);

    // Ack in the last allowed cycle wins over the timeout
    run(OP_LD, 32'h400, 32'h0, 1'b1, TIMEOUT, 32'hCAFE_F00D);
    chk("edge_ack_no_err", 32'(err), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nchk, nfail);
    $finish;
  end
endmodule
